// File: rtl/sm4_word_loader.sv
// sm4_word_loader
//   Collects a 32-bit word stream into the 128-bit key and content registers
//   feeding an SM4 encryptor. A transaction is either 4 key words followed by
//   4 content words (new_key_i=1 on the first word) or 4 content words that
//   reuse the stored key. The assembled block is then offered with v_o until
//   the encryptor takes it (ready_i). A free-running Galois LFSR supplies the
//   encryptor's random mask.
//
// Ports
//   clk_i, reset_i            clock, asynchronous active-high reset
//   word_i, word_v_i          stream word and valid; first word is bits [127:96]
//   word_ready_o              word accepted this cycle when high
//   new_key_i, decode_i,
//   protect_i                 transaction controls, sampled with the first word
//   key_o, content_o          assembled key / content
//   decode_o, protect_o       latched controls for the encryptor
//   random_o                  current LFSR state
//   v_o, ready_i              issue handshake towards the encryptor
//   err_o                     one-cycle pulse: content-only request, no key held
module sm4_word_loader #(
  parameter logic [31:0] seed_p = 32'hACE1_2468
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic [31:0]  word_i,
  input  logic         word_v_i,
  output logic         word_ready_o,
  input  logic         new_key_i,
  input  logic         decode_i,
  input  logic         protect_i,
  output logic [127:0] key_o,
  output logic [127:0] content_o,
  output logic         decode_o,
  output logic         protect_o,
  output logic [31:0]  random_o,
  output logic         v_o,
  input  logic         ready_i,
  output logic         err_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_KEY   = 2'd1,
    ST_DATA  = 2'd2,
    ST_ISSUE = 2'd3
  } state_t;

  // Feedback mask for x^32+x^22+x^2+x+1 in right-shifting Galois form.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  state_t        state_r;
  logic [1:0]    cnt_r;
  logic          key_valid_r;
  logic [127:0]  key_r;
  logic [127:0]  content_r;
  logic          decode_r;
  logic          protect_r;
  logic          v_r;
  logic          err_r;
  logic [31:0]   lfsr_r;
  logic          word_ready_s;
  logic          transfer_s;

  // One Galois step: shift right, fold the tap mask in when a one falls out.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    logic [31:0] n;
    n = {1'b0, s[31:1]};
    if (s[0]) begin
      n = n ^ LFSR_TAPS;
    end else begin
      n = n;
    end
    return n;
  endfunction

  // Replace word idx of a 128-bit block; index 0 is the most significant word.
  function automatic logic [127:0] put_word(input logic [127:0] vec,
                                            input logic [1:0]   idx,
                                            input logic [31:0]  w);
    logic [127:0] r;
    r = vec;
    case (idx)
      2'd0:    r[127:96] = w;
      2'd1:    r[95:64]  = w;
      2'd2:    r[63:32]  = w;
      2'd3:    r[31:0]   = w;
      default: r = vec;
    endcase
    return r;
  endfunction

  // Words are accepted in every state except ISSUE, and never during reset.
  always_comb begin
    word_ready_s = (state_r != ST_ISSUE) && !reset_i;
    transfer_s   = word_v_i && word_ready_s;
  end

  // Transaction sequencer: assembles key/content words and runs the issue handshake.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 2'd0;
      key_valid_r <= 1'b0;
      key_r       <= 128'd0;
      content_r   <= 128'd0;
      decode_r    <= 1'b0;
      protect_r   <= 1'b0;
      v_r         <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (transfer_s) begin
            if (new_key_i) begin
              // Loading a new key invalidates the old one until all 4 words land.
              key_r       <= put_word(key_r, 2'd0, word_i);
              decode_r    <= decode_i;
              protect_r   <= protect_i;
              key_valid_r <= 1'b0;
              cnt_r       <= 2'd1;
              state_r     <= ST_KEY;
            end else if (key_valid_r) begin
              content_r <= put_word(content_r, 2'd0, word_i);
              decode_r  <= decode_i;
              protect_r <= protect_i;
              cnt_r     <= 2'd1;
              state_r   <= ST_DATA;
            end else begin
              // No key to reuse: drop the word and flag it.
              err_r <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_KEY: begin
          if (transfer_s) begin
            key_r <= put_word(key_r, cnt_r, word_i);
            cnt_r <= cnt_r + 2'd1;
            if (cnt_r == 2'd3) begin
              key_valid_r <= 1'b1;
              state_r     <= ST_DATA;
            end else begin
              state_r <= ST_KEY;
            end
          end else begin
            state_r <= ST_KEY;
          end
        end
        ST_DATA: begin
          if (transfer_s) begin
            content_r <= put_word(content_r, cnt_r, word_i);
            cnt_r     <= cnt_r + 2'd1;
            if (cnt_r == 2'd3) begin
              v_r     <= 1'b1;
              state_r <= ST_ISSUE;
            end else begin
              state_r <= ST_DATA;
            end
          end else begin
            state_r <= ST_DATA;
          end
        end
        ST_ISSUE: begin
          if (ready_i) begin
            v_r     <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_ISSUE;
          end
        end
        default: begin
          v_r     <= 1'b0;
          cnt_r   <= 2'd0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Mask generator: free-running, advances every cycle.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      lfsr_r <= seed_p;
    end else begin
      lfsr_r <= lfsr_step(lfsr_r);
    end
  end

  assign word_ready_o = word_ready_s;
  assign key_o        = key_r;
  assign content_o    = content_r;
  assign decode_o     = decode_r;
  assign protect_o    = protect_r;
  assign random_o     = lfsr_r;
  assign v_o          = v_r;
  assign err_o        = err_r;

endmodule

// File: tb/tb_sm4_word_loader.sv
// Testbench for sm4_word_loader: directed table of transactions, directed
// corner sequences (no-key error, reset mid-load) and randomized transactions
// checked against a transaction-level model; LFSR checked every cycle.
module tb_sm4_word_loader;

  localparam logic [31:0] SEED = 32'hACE1_2468;
  localparam logic [127:0] K0  = 128'h0123456789ABCDEFFEDCBA9876543210;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic [31:0]  word_i;
  logic         word_v_i;
  logic         word_ready_o;
  logic         new_key_i;
  logic         decode_i;
  logic         protect_i;
  logic [127:0] key_o;
  logic [127:0] content_o;
  logic         decode_o;
  logic         protect_o;
  logic [31:0]  random_o;
  logic         v_o;
  logic         ready_i;
  logic         err_o;

  int tests  = 0;
  int failed = 0;
  bit lfsr_on = 1'b0;
  logic [31:0] m_lfsr;

  // Transaction-level model state
  logic         m_kv;
  logic [127:0] m_key;

  sm4_word_loader #(.seed_p(SEED)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .word_i(word_i), .word_v_i(word_v_i),
    .word_ready_o(word_ready_o), .new_key_i(new_key_i), .decode_i(decode_i),
    .protect_i(protect_i), .key_o(key_o), .content_o(content_o),
    .decode_o(decode_o), .protect_o(protect_o), .random_o(random_o),
    .v_o(v_o), .ready_i(ready_i), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference LFSR: polynomial x^32+x^22+x^2+x+1, Galois right-shift form.
  function automatic logic [31:0] galois(input logic [31:0] s);
    return (s >> 1) ^ ((s % 2 == 1) ? 32'h8020_0003 : 32'h0);
  endfunction

  always @(posedge clk_i or posedge reset_i) begin
    if (reset_i) m_lfsr <= SEED;
    else         m_lfsr <= galois(m_lfsr);
  end

  always @(negedge clk_i) begin
    if (lfsr_on) begin
      chk("lfsr", {96'd0, random_o}, {96'd0, m_lfsr});
      chk("lfsr_nonzero", {127'd0, random_o != 32'd0}, 128'd1);
    end
  end

  function automatic logic [31:0] getw(input logic [127:0] v, input int i);
    logic [127:0] t;
    t = v >> ((3 - i) * 32);
    return t[31:0];
  endfunction

  // Offer one word starting at a negedge; returns at the negedge after the transfer.
  task automatic send_word(input logic [31:0] w, input logic nk, input logic dec, input logic prot);
    int n;
    n = 0;
    word_i = w; new_key_i = nk; decode_i = dec; protect_i = prot; word_v_i = 1'b1;
    while (!word_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 50) chk("word_ready_timeout", {127'd0, word_ready_o}, 128'd1);
    @(negedge clk_i);
    word_v_i = 1'b0;
    word_i = $urandom;
    new_key_i = 1'($urandom); decode_i = 1'($urandom); protect_i = 1'($urandom);
  endtask

  task automatic idle_gap(input bit gaps);
    int g;
    g = gaps ? int'($urandom_range(0, 2)) : 0;
    for (int c = 0; c < g; c++) @(negedge clk_i);
  endtask

  // Full transaction + issue handshake with expected outputs.
  task automatic run_txn(input logic nk, input logic dec, input logic prot,
                         input logic [127:0] kw, input logic [127:0] cw,
                         input logic [127:0] ekey, input logic [127:0] econt,
                         input int hold, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      if (nk || i >= 4) begin
        idle_gap(gaps);
        if (i == 0 || (!nk && i == 4))
          send_word(i < 4 ? getw(kw, i) : getw(cw, i - 4), nk, dec, prot);
        else
          send_word(i < 4 ? getw(kw, i) : getw(cw, i - 4),
                    1'($urandom), 1'($urandom), 1'($urandom));
      end
    end
    // Last content word accepted on the previous edge: v_o must already be up.
    chk("issue_latency", {127'd0, v_o}, 128'd1);
    chk("key", key_o, ekey);
    chk("content", content_o, econt);
    chk("decode", {127'd0, decode_o}, {127'd0, dec});
    chk("protect", {127'd0, protect_o}, {127'd0, prot});
    chk("ready_in_issue", {127'd0, word_ready_o}, 128'd0);
    for (int c = 0; c < hold; c++) begin
      @(negedge clk_i);
      chk("hold_v", {127'd0, v_o}, 128'd1);
      chk("hold_key", key_o, ekey);
      chk("hold_content", content_o, econt);
      chk("hold_ctl", {126'd0, decode_o, protect_o}, {126'd0, dec, prot});
      chk("hold_ready", {127'd0, word_ready_o}, 128'd0);
    end
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
    chk("post_issue_v", {127'd0, v_o}, 128'd0);
    chk("post_issue_ready", {127'd0, word_ready_o}, 128'd1);
  endtask

  task automatic err_case(input logic [31:0] w);
    send_word(w, 1'b0, 1'($urandom), 1'($urandom));
    chk("err_pulse", {127'd0, err_o}, 128'd1);
    chk("err_no_v", {127'd0, v_o}, 128'd0);
    chk("err_ready", {127'd0, word_ready_o}, 128'd1);
    @(negedge clk_i);
    chk("err_one_cycle", {127'd0, err_o}, 128'd0);
    chk("err_no_v2", {127'd0, v_o}, 128'd0);
  endtask

  task automatic pulse_reset();
    reset_i = 1'b1;
    #1;
    chk("rst_v", {127'd0, v_o}, 128'd0);
    chk("rst_key", key_o, 128'd0);
    chk("rst_content", content_o, 128'd0);
    chk("rst_ready", {127'd0, word_ready_o}, 128'd0);
    chk("rst_err_ctl", {125'd0, err_o, decode_o, protect_o}, 128'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    m_kv = 1'b0;
    m_key = 128'd0;
  endtask

  typedef struct {
    logic         nk, dec, prot;
    logic [127:0] kw, cw, ekey, econt;
    int           hold;
  } vec_t;

  vec_t tbl[4];

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, K0, K0, K0, K0, 10};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 128'd0,
               128'hAAAAAAAABBBBBBBBCCCCCCCCDDDDDDDD, K0,
               128'hAAAAAAAABBBBBBBBCCCCCCCCDDDDDDDD, 3};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 128'h11111111222222223333333344444444,
               128'h55555555666666667777777788888888,
               128'h11111111222222223333333344444444,
               128'h55555555666666667777777788888888, 0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 128'd0,
               128'h9999999900000000DEADBEEFCAFEF00D,
               128'h11111111222222223333333344444444,
               128'h9999999900000000DEADBEEFCAFEF00D, 1};

    reset_i = 1'b1; word_i = 32'd0; word_v_i = 1'b0; new_key_i = 1'b0;
    decode_i = 1'b0; protect_i = 1'b0; ready_i = 1'b0;
    m_kv = 1'b0; m_key = 128'd0;
    repeat (3) @(negedge clk_i);
    chk("reset_ready", {127'd0, word_ready_o}, 128'd0);
    chk("reset_v", {127'd0, v_o}, 128'd0);
    chk("reset_key", key_o, 128'd0);
    chk("reset_content", content_o, 128'd0);
    chk("reset_err", {127'd0, err_o}, 128'd0);
    chk("reset_random", {96'd0, random_o}, {96'd0, SEED});
    reset_i = 1'b0;
    #1;
    chk("release_random", {96'd0, random_o}, {96'd0, SEED});
    chk("release_ready", {127'd0, word_ready_o}, 128'd1);
    lfsr_on = 1'b1;
    @(negedge clk_i);

    // Content-only request with no key held.
    err_case(32'hAAAAAAAA);

    // Directed table.
    for (int t = 0; t < 4; t++) begin
      run_txn(tbl[t].nk, tbl[t].dec, tbl[t].prot, tbl[t].kw, tbl[t].cw,
              tbl[t].ekey, tbl[t].econt, tbl[t].hold, 1'b0);
    end

    // Reset after two key words discards the partial group.
    send_word(32'h01234567, 1'b1, 1'b1, 1'b1);
    send_word(32'h89ABCDEF, 1'b0, 1'b0, 1'b0);
    pulse_reset();
    err_case(32'h12345678);
    run_txn(1'b1, 1'b0, 1'b0, K0, K0, K0, K0, 2, 1'b0);
    m_kv = 1'b1; m_key = K0;

    // Randomized transactions against the model.
    for (int t = 0; t < 60; t++) begin
      logic nk, dec, prot;
      logic [127:0] kw, cw;
      if ($urandom_range(0, 9) == 0) pulse_reset();
      nk = 1'($urandom); dec = 1'($urandom); prot = 1'($urandom);
      kw = {$urandom, $urandom, $urandom, $urandom};
      cw = {$urandom, $urandom, $urandom, $urandom};
      if (!nk && !m_kv) begin
        err_case(cw[127:96]);
      end else begin
        if (nk) begin
          m_key = kw;
          m_kv = 1'b1;
        end
        run_txn(nk, dec, prot, kw, cw, m_key, cw, int'($urandom_range(0, 3)), 1'b1);
      end
    end

    lfsr_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/sm4_word_loader.md
SM4_WORD_LOADER -- requirements
Module: sm4_word_loader

Interface
REQ-001 Parameter seed_p, default 32'hACE1_2468, reset value of the mask LFSR; SHALL be nonzero.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 reset_i  input  1  asynchronous, active-high reset.
REQ-004 word_i  input  32  stream word; first word of a group is bits [127:96].
REQ-005 word_v_i  input  1  word_i valid.
REQ-006 word_ready_o  output  1  loader accepts word this cycle; transfer = word_v_i & word_ready_o.
REQ-007 new_key_i  input  1  sampled with first word of a transaction: 1 = 4 key words then 4 content words; 0 = 4 content words, reuse stored key.
REQ-008 decode_i  input  1  sampled with first word; 1 = decrypt.
REQ-009 protect_i  input  1  sampled with first word; fault-protection request.
REQ-010 key_o  output  128  assembled key, to encryptor key_i.
REQ-011 content_o  output  128  assembled content, to encryptor content_i.
REQ-012 decode_o  output  1  registered decode_i, to encode_or_decode_i.
REQ-013 protect_o  output  1  registered protect_i, to protection_v_i.
REQ-014 random_o  output  32  LFSR value, to random_i.
REQ-015 v_o  output  1  key_o/content_o/decode_o/protect_o valid.
REQ-016 ready_i  input  1  encryptor ready_o; issue transfer = v_o & ready_i.
REQ-017 err_o  output  1  one-cycle pulse: content-only transaction with no stored key.

Function
REQ-018 States: IDLE, KEY, DATA, ISSUE; 2-bit word counter cnt.
REQ-019 word_ready_o = 1 in IDLE, KEY, DATA; 0 in ISSUE and while reset_i high.
REQ-020 IDLE, transfer, new_key_i=1: word -> key[127:96], latch decode/protect, clear key_valid, cnt=1, -> KEY.
REQ-021 IDLE, transfer, new_key_i=0, key_valid=1: word -> content[127:96], latch decode/protect, cnt=1, -> DATA.
REQ-022 IDLE, transfer, new_key_i=0, key_valid=0: word dropped, err_o=1 next cycle for one cycle, stay IDLE.
REQ-023 KEY: each transfer writes key word index cnt (index 0 = [127:96], 3 = [31:0]), cnt+1; on cnt==3 transfer set key_valid, cnt=0, -> DATA.
REQ-024 DATA: each transfer writes content word index cnt, cnt+1; on cnt==3 transfer -> ISSUE (cnt wraps to 0).
REQ-025 In KEY/DATA new_key_i, decode_i, protect_i are ignored; no word_v_i = hold, no timeout.
REQ-026 ISSUE: v_o=1; on ready_i=1 -> IDLE next cycle; v_o low in all other states.
REQ-027 Outputs held stable while v_o=1 and ready_i=0.
REQ-028 Latency: last content word accepted cycle N -> v_o=1 cycle N+1; minimum 1 idle cycle between issues.
REQ-029 Key register retained across transactions until next new_key_i=1 transaction or reset.
REQ-030 LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1, advances every cycle, random_o = current state.

Reset
REQ-031 reset_i asserted at any time (incl. mid-KEY/DATA/ISSUE) immediately forces: IDLE, cnt=0, key_valid=0, key_o=0, content_o=0, decode_o=0, protect_o=0, v_o=0, err_o=0, LFSR=seed_p, partial group discarded.
REQ-032 First post-reset edge with word_v_i=1 SHALL accept a word.

Verification
REQ-033 Reset, send new_key_i=1 words 01234567,89ABCDEF,FEDCBA98,76543210 then same 4 as content, decode_i=0 -> v_o next cycle, key_o=content_o=0123456789ABCDEFFEDCBA9876543210, decode_o=0.
REQ-034 After REQ-033 issue, content-only AAAAAAAA,BBBBBBBB,CCCCCCCC,DDDDDDDD -> key_o unchanged, content_o=AAAAAAAABBBBBBBBCCCCCCCCDDDDDDDD.
REQ-035 After reset, content-only first word -> err_o one-cycle pulse, word_ready_o stays 1, no v_o.
REQ-036 v_o=1 with ready_i=0 for 10 cycles -> outputs stable, word_ready_o=0; ready_i=1 -> IDLE next cycle.
REQ-037 Reset asserted after 2 key words -> v_o=0, key_o=0; new 8-word transaction completes normally.
REQ-038 random_o = seed_p at reset release, then matches Galois model over 1000 cycles, never 0.
